// File: rtl/seq_shift_add_multiplier.sv
// Multi-cycle shift-and-add multiplier, one partial product per clock, with a start/done
// handshake and a run-time choice between unsigned and two's-complement operands.
module seq_shift_add_multiplier #(
   parameter int M = 8,
   parameter int N = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [M-1:0]     a,
   input  logic [N-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic [M+N-1:0]   c
);

   localparam int W  = M + N;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            neg_q, neg_d;
   logic [W-1:0]    ma_q, ma_d;
   logic [N-1:0]    mb_q, mb_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    c_q, c_d;
   logic            done_q, done_d;

   logic            a_neg, b_neg;
   logic [M-1:0]    a_mag;
   logic [N-1:0]    b_mag;
   logic [W-1:0]    addend;

   // Operands are multiplied as magnitudes; the sign is reapplied once at the end.
   // The most negative value negates to itself, which reads correctly as unsigned.
   assign a_neg = signed_mode & a[M-1];
   assign b_neg = signed_mode & b[N-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   // Partial product: the shifted multiplicand gated by the current multiplier bit.
   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_addend
         assign addend[gi] = ma_q[gi] & mb_q[0];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      neg_d   = neg_q;
      ma_d    = ma_q;
      mb_d    = mb_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               neg_d   = a_neg ^ b_neg;
               ma_d    = {{N{1'b0}}, a_mag};
               mb_d    = b_mag;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            acc_d = acc_q + addend;
            ma_d  = ma_q << 1;
            mb_d  = mb_q >> 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            c_d     = neg_q ? -acc_q : acc_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         neg_q   <= 1'b0;
         ma_q    <= '0;
         mb_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         c_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         neg_q   <= neg_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign c    = c_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: two multiplier instances (8x8 and 12x5) driven with directed and
// random operands, compared against plain integer multiplication.
module tb_seq_shift_add_multiplier;

   logic         clk;
   logic         rst;

   logic         start8, sm8, busy8, done8;
   logic [7:0]   a8, b8;
   logic [15:0]  c8;

   logic         start12, sm12, busy12, done12;
   logic [11:0]  a12;
   logic [4:0]   b12;
   logic [16:0]  c12;

   int checks_total  = 0;
   int checks_passed = 0;

   seq_shift_add_multiplier #(.M(8), .N(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .c(c8)
   );

   seq_shift_add_multiplier #(.M(12), .N(5)) u_dut12 (
      .clk(clk), .rst(rst), .start(start12), .signed_mode(sm12),
      .a(a12), .b(b12), .busy(busy12), .done(done12), .c(c12)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_total++;
      if (obs === exp) checks_passed++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
   endtask

   // Reference: interpret operands as integers and multiply, keep M+N low bits.
   function automatic longint ref_product(input int m, input int n, input bit sm,
                                          input longint av, input longint bv);
      longint va, vb;
      va = av;
      vb = bv;
      if (sm && av[m-1]) va = av - (longint'(1) << m);
      if (sm && bv[n-1]) vb = bv - (longint'(1) << n);
      return (va * vb) & ((longint'(1) << (m + n)) - 1);
   endfunction

   // Called on a negedge; returns on the negedge at which done is seen.
   task automatic run_op(input bit sel, input bit sm, input longint av_in, input longint bv_in,
                         input bit disturb, input string tag);
      int          m, n, cyc, busy_cnt;
      longint      av, bv, exp;
      logic [63:0] obs;
      m   = sel ? 12 : 8;
      n   = sel ? 5 : 8;
      av  = av_in & ((longint'(1) << m) - 1);
      bv  = bv_in & ((longint'(1) << n) - 1);
      exp = ref_product(m, n, sm, av, bv);
      if (sel) begin
         start12 = 1'b1; sm12 = sm; a12 = av[11:0]; b12 = bv[4:0];
      end else begin
         start8 = 1'b1; sm8 = sm; a8 = av[7:0]; b8 = bv[7:0];
      end
      @(negedge clk);
      start8  = 1'b0;
      start12 = 1'b0;
      cyc      = 1;
      busy_cnt = 0;
      while ((sel ? done12 : done8) !== 1'b1 && cyc < 64) begin
         if ((sel ? busy12 : busy8) === 1'b1) busy_cnt++;
         if (disturb) begin
            if (cyc >= 2 && cyc <= 4) begin
               start8 = 1'b1; sm8 = ~sm8; a8 = 8'($urandom); b8 = 8'($urandom);
            end else begin
               start8 = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      obs = sel ? 64'(c12) : 64'(c8);
      check({tag, "_lat"}, 64'(cyc), 64'(n + 2));
      check({tag, "_busy"}, 64'(busy_cnt), 64'(n + 1));
      check({tag, "_busy_at_done"}, 64'(sel ? busy12 : busy8), 64'd0);
      check({tag, "_c"}, obs, 64'(exp));
      $display("op %s: inst=%0dx%0d signed=%0d a=%0h b=%0h c=%0h exp=%0h lat=%0d",
               tag, m, n, sm, av, bv, obs, exp, cyc);
   endtask

   task automatic watch_idle(input int cycles, input string tag);
      int hits;
      hits = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done8 !== 1'b0 || done12 !== 1'b0 || busy8 !== 1'b0 || busy12 !== 1'b0) hits++;
      end
      check(tag, 64'(hits), 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      start12 = 1'b0; sm12 = 1'b0; a12 = '0; b12 = '0;
      repeat (2) @(negedge clk);
      check("rst_c8", 64'(c8), 64'd0);
      check("rst_done8", 64'(done8), 64'd0);
      check("rst_busy8", 64'(busy8), 64'd0);
      check("rst_c12", 64'(c12), 64'd0);
      check("rst_done12", 64'(done12), 64'd0);
      rst = 1'b0;
      watch_idle(20, "idle_after_rst");

      run_op(0, 0, 13, 11, 0, "u13x11");
      check("u13x11_exact", 64'(c8), 64'h008F);
      @(negedge clk);
      check("done_one_cycle", 64'(done8), 64'd0);
      check("c_holds", 64'(c8), 64'h008F);

      run_op(0, 0, 'hFF, 'hFF, 0, "uFFxFF");
      check("uFFxFF_exact", 64'(c8), 64'hFE01);
      run_op(0, 1, 'h80, 'h80, 0, "s80x80");
      check("s80x80_exact", 64'(c8), 64'h4000);
      run_op(0, 1, 'h80, 'h7F, 0, "s80x7F");
      check("s80x7F_exact", 64'(c8), 64'hC080);
      run_op(0, 1, 'hFD, 5, 0, "sm3x5");
      check("sm3x5_exact", 64'(c8), 64'hFFF1);
      run_op(0, 1, 'h80, 0, 0, "szero");
      run_op(0, 0, 0, 'hFF, 0, "uzero");
      @(negedge clk);

      run_op(0, 1, 'hF3, 'h25, 1, "ignore_busy");
      run_op(0, 0, 'hC7, 'h3B, 0, "b2b_second");
      @(negedge clk);

      run_op(1, 1, 'h800, 'h10, 0, "s12_min");
      check("s12_min_exact", 64'(c12), 64'h08000);
      run_op(1, 0, 'hFFF, 'h1F, 0, "u12_max");
      @(negedge clk);

      // Abort an operation in its 4th CALC cycle; nothing may complete.
      start8 = 1'b1; sm8 = 1'b0; a8 = 8'd200; b8 = 8'd3;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(busy8), 64'd0);
      check("abort_done", 64'(done8), 64'd0);
      check("abort_c", 64'(c8), 64'd0);
      rst = 1'b0;
      watch_idle(20, "abort_no_done");
      run_op(0, 1, 'h9C, 'h47, 0, "after_abort");
      @(negedge clk);

      for (int i = 0; i < 2500; i++) begin
         run_op(0, 1'($urandom), longint'($urandom), longint'($urandom), 0, "rnd8x8");
      end
      @(negedge clk);
      for (int i = 0; i < 2500; i++) begin
         run_op(1, 1'($urandom), longint'($urandom), longint'($urandom), 0, "rnd12x5");
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
